// File: rtl/screen_pkg.sv
// Shared constants, FSM state encoding and sprite-slot record for the
// screen draw scheduler.
package screen_pkg;

  localparam int SCR_W   = 320;
  localparam int SCR_H   = 240;
  localparam int SPR_DIM = 16;
  localparam int SPR_LOG = $clog2(SPR_DIM);
  localparam int NSLOT   = 6;

  localparam logic [4:0] ID_EMPTY = 5'd0;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SLOT,
    DRAW,
    FIN
  } state_t;

  // Bit layout matches {slot_id[k], slot_xy[k]} so a slot latches in one copy.
  typedef struct packed {
    logic [4:0] id;
    logic [8:0] x;
    logic [7:0] y;
  } slot_t;

endpackage

// File: rtl/sprite_raster_counter.sv
// Column-inner / row-outer scan counter with a last-position flag; used for
// both the full-screen clear raster and the per-sprite scan.
module sprite_raster_counter #(
  parameter int COLS = 16,
  parameter int ROWS = 16,
  parameter int CW   = 4,
  parameter int RW   = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          last
);

  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr) begin
      col_d = '0;
      row_d = '0;
    end else if (en) begin
      if (col_q == COL_MAX) begin
        col_d = '0;
        row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col  = col_q;
  assign row  = row_q;
  assign last = (col_q == COL_MAX) && (row_q == ROW_MAX);

endmodule

// File: rtl/screen_draw_scheduler.sv
// Frame repaint sequencer: background clear followed by up to NSLOT sprites.
// Define SPRITE_TRANSPARENT_EN to treat ROM colour 12'h000 as transparent.
module screen_draw_scheduler
  import screen_pkg::*;
#(
  parameter int SCR_W = screen_pkg::SCR_W,
  parameter int SCR_H = screen_pkg::SCR_H
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic                 redraw,
  input  logic [11:0]          background,
  input  logic [5*NSLOT-1:0]   slot_id,
  input  logic [17*NSLOT-1:0]  slot_xy,
  output logic [12:0]          rom_addr,
  input  logic [11:0]          rom_data,
  output logic [8:0]           vga_x,
  output logic [7:0]           vga_y,
  output logic [11:0]          vga_colour,
  output logic                 vga_plot,
  output logic                 busy,
  output logic                 done
);

  // Handshake: redraw is a one-cycle request, never dropped; one request is
  // queued while busy. done pulses in the cycle busy falls. rom_data must be
  // the word for the rom_addr presented in the previous cycle.

  localparam int KW = $clog2(NSLOT);

  state_t             state_q, state_d;
  logic [KW-1:0]      k_q, k_d;
  logic               drain_q, drain_d;
  logic               pending_q, pending_d;
  logic [11:0]        bg_q, bg_d;
  slot_t              shadow_q [NSLOT];
  slot_t              shadow_d [NSLOT];
  logic               pvalid_q, pvalid_d;
  logic               psrc_q, psrc_d;
  logic [8:0]         px_q, px_d;
  logic [7:0]         py_q, py_d;

  logic               rc_clr, rc_en, rc_last;
  logic [8:0]         rc_col;
  logic [7:0]         rc_row;
  logic               sc_clr, sc_en, sc_last;
  logic [SPR_LOG-1:0] sc_col, sc_row;

  slot_t              cur;
  logic [9:0]         sum_x;
  logic [8:0]         sum_y;
  logic               in_bounds;

  sprite_raster_counter #(.COLS(SCR_W), .ROWS(SCR_H), .CW(9), .RW(8)) u_raster (
    .clk(CLOCK_50), .reset(reset), .clr(rc_clr), .en(rc_en),
    .col(rc_col), .row(rc_row), .last(rc_last)
  );

  sprite_raster_counter #(.COLS(SPR_DIM), .ROWS(SPR_DIM), .CW(SPR_LOG), .RW(SPR_LOG)) u_sprite (
    .clk(CLOCK_50), .reset(reset), .clr(sc_clr), .en(sc_en),
    .col(sc_col), .row(sc_row), .last(sc_last)
  );

  // Wider sums keep corners near 511/255 from wrapping back on screen.
  assign cur       = shadow_q[k_q];
  assign sum_x     = {1'b0, cur.x} + {6'd0, sc_col};
  assign sum_y     = {1'b0, cur.y} + {5'd0, sc_row};
  assign in_bounds = (sum_x < 10'(SCR_W)) && (sum_y < 9'(SCR_H));

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    drain_d   = drain_q;
    pending_d = pending_q;
    bg_d      = bg_q;
    shadow_d  = shadow_q;
    pvalid_d  = 1'b0;
    psrc_d    = psrc_q;
    px_d      = px_q;
    py_d      = py_q;
    rc_clr    = 1'b0;
    rc_en     = 1'b0;
    sc_clr    = 1'b0;
    sc_en     = 1'b0;
    rom_addr  = '0;
    if (state_q != IDLE) pending_d = pending_q | redraw;
    case (state_q)
      IDLE: begin
        rc_clr    = 1'b1;
        pending_d = 1'b0;
        if (redraw || pending_q) begin
          state_d = CLEAR;
          k_d     = '0;
          bg_d    = background;
          for (int i = 0; i < NSLOT; i++) begin
            shadow_d[i] = {slot_id[5*i +: 5], slot_xy[17*i +: 17]};
          end
        end
      end
      CLEAR: begin
        rc_en    = 1'b1;
        pvalid_d = 1'b1;
        psrc_d   = 1'b0;
        px_d     = rc_col;
        py_d     = rc_row;
        if (rc_last) state_d = SLOT;
      end
      SLOT: begin
        sc_clr  = 1'b1;
        drain_d = 1'b0;
        if (cur.id != ID_EMPTY) begin
          state_d = DRAW;
        end else if (k_q == KW'(NSLOT - 1)) begin
          state_d = FIN;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DRAW: begin
        if (!drain_q) begin
          rom_addr = {cur.id, sc_row, sc_col};
          sc_en    = 1'b1;
          psrc_d   = 1'b1;
          if (in_bounds) begin
            pvalid_d = 1'b1;
            px_d     = sum_x[8:0];
            py_d     = sum_y[7:0];
          end
          if (sc_last) drain_d = 1'b1;
        end else begin
          drain_d = 1'b0;
          if (k_q == KW'(NSLOT - 1)) begin
            state_d = FIN;
          end else begin
            k_d     = k_q + 1'b1;
            state_d = SLOT;
          end
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= IDLE;
      k_q       <= '0;
      drain_q   <= 1'b0;
      pending_q <= 1'b0;
      bg_q      <= '0;
      shadow_q  <= '{default: '0};
      pvalid_q  <= 1'b0;
      psrc_q    <= 1'b0;
      px_q      <= '0;
      py_q      <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      drain_q   <= drain_d;
      pending_q <= pending_d;
      bg_q      <= bg_d;
      shadow_q  <= shadow_d;
      pvalid_q  <= pvalid_d;
      psrc_q    <= psrc_d;
      px_q      <= px_d;
      py_q      <= py_d;
    end
  end

  assign vga_x      = px_q;
  assign vga_y      = py_q;
  assign vga_colour = psrc_q ? rom_data : bg_q;
`ifdef SPRITE_TRANSPARENT_EN
  assign vga_plot   = pvalid_q & ~(psrc_q & (rom_data == 12'h000));
`else
  assign vga_plot   = pvalid_q;
`endif
  assign busy       = (state_q == CLEAR) || (state_q == SLOT) || (state_q == DRAW);
  assign done       = (state_q == FIN);

endmodule

// File: tb/tb_screen_draw_scheduler.sv
// Self-checking bench for screen_draw_scheduler on a reduced 48x32 screen;
// expected plot streams are queued at frame start and consumed as plots appear.
module tb_screen_draw_scheduler;
  import screen_pkg::*;

  localparam int W = 48;
  localparam int H = 32;

  logic                clk = 1'b0;
  logic                reset;
  logic                redraw;
  logic [11:0]         background;
  logic [5*NSLOT-1:0]  slot_id;
  logic [17*NSLOT-1:0] slot_xy;
  logic [12:0]         rom_addr;
  logic [11:0]         rom_data = '0;
  logic [8:0]          vga_x;
  logic [7:0]          vga_y;
  logic [11:0]         vga_colour;
  logic                vga_plot;
  logic                busy;
  logic                done;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [28:0] exp_q[$];
  logic [28:0] exp_e;
  logic [4:0]  tb_id [NSLOT];
  logic [16:0] tb_xy [NSLOT];
  logic [4:0]  rom_zero_id = '0;

  always #5 clk = ~clk;

  screen_draw_scheduler #(.SCR_W(W), .SCR_H(H)) dut (
    .CLOCK_50(clk), .reset(reset), .redraw(redraw), .background(background),
    .slot_id(slot_id), .slot_xy(slot_xy), .rom_addr(rom_addr), .rom_data(rom_data),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .busy(busy), .done(done)
  );

  function automatic logic [11:0] rom_fn(input logic [12:0] a);
    if (rom_zero_id != 5'd0 && a[12:8] == rom_zero_id) return 12'h000;
    return a[11:0];
  endfunction

  always @(posedge clk) rom_data <= rom_fn(rom_addr);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && vga_plot) begin
      check_eq("plot_busy", 32'(busy), 32'd1);
      check_eq("plot_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_e = exp_q.pop_front();
        check_eq("plot_pix", {3'b0, vga_x, vga_y, vga_colour}, {3'b0, exp_e});
      end
    end
  end

  task automatic apply_slots();
    for (int i = 0; i < NSLOT; i++) begin
      slot_id[5*i +: 5]  = tb_id[i];
      slot_xy[17*i +: 17] = tb_xy[i];
    end
  endtask

  task automatic clear_slots();
    for (int i = 0; i < NSLOT; i++) begin
      tb_id[i] = 5'd0;
      tb_xy[i] = 17'($urandom_range(0, 131071));
    end
    apply_slots();
  endtask

  task automatic push_frame(input logic [11:0] bg);
    int px, py;
    logic [11:0] colr;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        exp_q.push_back({9'(x), 8'(y), bg});
    for (int s = 0; s < NSLOT; s++) begin
      if (tb_id[s] != 5'd0) begin
        for (int r = 0; r < SPR_DIM; r++) begin
          for (int c = 0; c < SPR_DIM; c++) begin
            px = int'(tb_xy[s][16:8]) + c;
            py = int'(tb_xy[s][7:0]) + r;
            if (px < W && py < H) begin
              colr = rom_fn({tb_id[s], 4'(r), 4'(c)});
`ifdef SPRITE_TRANSPARENT_EN
              if (colr != 12'h000)
`endif
                exp_q.push_back({9'(px), 8'(py), colr});
            end
          end
        end
      end
    end
  endtask

  function automatic int frame_lat();
    int lat;
    lat = W * H + 1;
    for (int s = 0; s < NSLOT; s++) lat += (tb_id[s] != 5'd0) ? 258 : 1;
    return lat;
  endfunction

  task automatic pulse_redraw();
    @(negedge clk);
    redraw = 1'b1;
    @(negedge clk);
    redraw = 1'b0;
  endtask

  // c counts cycles after the start cycle; done must appear at c == lat.
  task automatic wait_done(input int lat, input int c0, input string tag,
                           input bit redraw_at_done, input int remain);
    int c;
    c = c0;
    while (!done && c < lat + 100) begin
      if (c == 1) check_eq({tag, "_busy"}, 32'(busy), 32'd1);
      @(negedge clk);
      c++;
    end
    check_eq({tag, "_lat"}, c, lat);
    check_eq({tag, "_busy_fin"}, 32'(busy), 32'd0);
    if (redraw_at_done) redraw = 1'b1;
    @(negedge clk);
    redraw = 1'b0;
    check_eq({tag, "_done_pulse"}, 32'(done), 32'd0);
    check_eq({tag, "_drained"}, exp_q.size(), remain);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw;
    int lat;
    reset = 1'b1;
    redraw = 1'b0;
    background = '0;
    clear_slots();
    repeat (3) @(negedge clk);
    check_eq("rst_plot", 32'(vga_plot), 32'd0);
    check_eq("rst_xy", {15'd0, vga_x, vga_y}, 32'd0);
    check_eq("rst_colour", 32'(vga_colour), 32'd0);
    check_eq("rst_busy_done", {30'd0, busy, done}, 32'd0);
    check_eq("rst_rom_addr", 32'(rom_addr), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Plain background frame, no sprites.
    background = 12'h077;
    push_frame(12'h077);
    lat = frame_lat();
    pulse_redraw();
    background = 12'($urandom_range(0, 4095));
    wait_done(lat, 1, "bg", 1'b0, 0);

    // Sprites: in-bounds, edge clip, far clip (no wrap), empty slot, overlap.
    tb_id[0] = 5'd1;  tb_xy[0] = {9'd4,   8'd4};
    tb_id[1] = 5'd0;
    tb_id[2] = 5'd5;  tb_xy[2] = {9'd24,  8'd8};
    tb_id[3] = 5'd1;  tb_xy[3] = {9'd40,  8'd28};
    tb_id[4] = 5'd3;  tb_xy[4] = {9'd500, 8'd250};
    tb_id[5] = 5'd2;  tb_xy[5] = {9'd4,   8'd4};
    rom_zero_id = 5'd2;
    apply_slots();
    background = 12'h123;
    push_frame(12'h123);
    lat = frame_lat();
    pulse_redraw();
    clear_slots();
    background = 12'hfff;
    wait_done(lat, 1, "spr", 1'b0, 0);
    rom_zero_id = 5'd0;

    // Queued requests: two pulses mid-frame give one extra frame; a pulse
    // in the done cycle queues exactly one more.
    background = 12'h0a5;
    push_frame(12'h0a5);
    push_frame(12'h0a5);
    push_frame(12'h0a5);
    lat = frame_lat();
    pulse_redraw();
    repeat (300) @(negedge clk);
    pulse_redraw();
    repeat (300) @(negedge clk);
    pulse_redraw();
    wait_done(lat, 605, "q1", 1'b0, 2 * W * H);
    wait_done(lat, 0, "q2", 1'b1, W * H);
    wait_done(lat, 0, "q3", 1'b0, 0);
    saw = 1'b0;
    repeat (400) begin
      @(negedge clk);
      saw |= busy | done;
    end
    check_eq("no_extra_frame", 32'(saw), 32'd0);

    // Reset in the middle of the clear raster.
    background = 12'h3c3;
    push_frame(12'h3c3);
    pulse_redraw();
    repeat (500) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("midrst_plot", 32'(vga_plot), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    exp_q.delete();
    saw = 1'b0;
    repeat (300) begin
      @(negedge clk);
      saw |= busy | done | vga_plot;
    end
    check_eq("midrst_quiet", 32'(saw), 32'd0);
    background = 12'h5a0;
    push_frame(12'h5a0);
    lat = frame_lat();
    pulse_redraw();
    wait_done(lat, 1, "after_rst", 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
